// File: rtl/counter_unit_if.sv
// Control/status bundle for counter_unit: inhibit in, count and carry out.
// Optional parallel-load signals appear when COUNTER_UNIT_LOAD_EN is defined.
interface counter_unit_if #(
  parameter int SIZE = 8
);
  localparam int W = SIZE + 2;

  logic         clockinh;
  logic [W-1:0] countoutput;
  logic         carryout;
`ifdef COUNTER_UNIT_LOAD_EN
  logic         load;
  logic [W-1:0] loadvalue;

  modport master (output clockinh, output load, output loadvalue,
                  input  countoutput, input carryout);
  modport slave  (input  clockinh, input  load, input  loadvalue,
                  output countoutput, output carryout);
`else
  modport master (output clockinh, input countoutput, input carryout);
  modport slave  (input  clockinh, output countoutput, output carryout);
`endif
endinterface

// File: rtl/counter_unit.sv
// Cascadable W = SIZE+2 bit binary up-counter with clock inhibit and carry out.
// Define COUNTER_UNIT_LOAD_EN to add a synchronous parallel load.
module counter_unit #(
  parameter int SIZE = 8
) (
  input  logic           clock,
  input  logic           reset,
  counter_unit_if.slave  bus
);
  localparam int W = SIZE + 2;
  localparam logic [W-1:0] one      = W'(1);
  localparam logic [W-1:0] all_ones = '1;

  logic [W-1:0] count;
  logic         carry;

  // Increment only on an explicit 0, so an unknown inhibit holds the count.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and simulation matches the synthesized flops.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
`ifdef COUNTER_UNIT_LOAD_EN
      if (bus.load == 1'b1) begin
        count <= bus.loadvalue;
      end else if (bus.clockinh == 1'b0) begin
        count <= count + one;
      end
`else
      if (bus.clockinh == 1'b0) begin
        count <= count + one;
      end
`endif
    end
  end

  // NOTE: carry gets a default before the condition so no latch is inferred.
  always_comb begin
    carry = 1'b0;
    if (bus.clockinh == 1'b0) begin
      carry = (count == all_ones);
    end
  end

  assign bus.countoutput = count;
  assign bus.carryout    = carry;

endmodule

// File: tb/tb_counter_unit.sv
// Scoreboard bench for counter_unit: directed stimulus queues expectations,
// a monitor pops and compares. Load checks run when COUNTER_UNIT_LOAD_EN is defined.
module tb_counter_unit;
  localparam int SIZE = 8;
  localparam int W    = SIZE + 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  counter_unit_if #(.SIZE(SIZE)) bus_main ();
  counter_unit_if #(.SIZE(SIZE)) bus_lo ();
  counter_unit_if #(.SIZE(SIZE)) bus_hi ();

  counter_unit #(.SIZE(SIZE)) dut  (.clock(clock), .reset(reset), .bus(bus_main));
  counter_unit #(.SIZE(SIZE)) u_lo (.clock(clock), .reset(reset), .bus(bus_lo));
  counter_unit #(.SIZE(SIZE)) u_hi (.clock(clock), .reset(reset), .bus(bus_hi));

  // Low stage carry enables the high stage: a 2W-bit counter.
  assign bus_hi.clockinh = ~bus_lo.carryout;
`ifdef COUNTER_UNIT_LOAD_EN
  assign bus_lo.load      = 1'b0;
  assign bus_lo.loadvalue = '0;
  assign bus_hi.load      = 1'b0;
  assign bus_hi.loadvalue = '0;
`endif

  typedef struct {
    string        name;
    int           sel;
    logic [W-1:0] count;
    logic         carry;
  } exp_t;

  exp_t sb[$];
  event sample_ev;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int sel,
                       input logic [W-1:0] c, input logic carry);
    exp_t e;
    e.name  = name;
    e.sel   = sel;
    e.count = c;
    e.carry = carry;
    sb.push_back(e);
    ->sample_ev;
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    exp_t         e;
    logic [W-1:0] act_c;
    logic         act_y;
    forever begin
      @(sample_ev);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        case (e.sel)
          1:       begin act_c = bus_lo.countoutput;   act_y = bus_lo.carryout;   end
          2:       begin act_c = bus_hi.countoutput;   act_y = bus_hi.carryout;   end
          default: begin act_c = bus_main.countoutput; act_y = bus_main.carryout; end
        endcase
        n_checks++;
        if (act_c === e.count && act_y === e.carry)
          n_pass++;
        else
          $display("FAIL %s: got count=%0d carry=%b, expected count=%0d carry=%b",
                   e.name, act_c, act_y, e.count, e.carry);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    reset             = 1'b0;
    bus_main.clockinh = 1'b0;
    bus_lo.clockinh   = 1'b1;
`ifdef COUNTER_UNIT_LOAD_EN
    bus_main.load      = 1'b0;
    bus_main.loadvalue = '0;
`endif
    #3;
    check("reset_main", 0, 0, 1'b0);
    check("reset_lo",   1, 0, 1'b0);
    check("reset_hi",   2, 0, 1'b0);

    @(negedge clock);
    reset = 1'b1;
    tick(32);
    check("count_32", 0, 32, 1'b0);
    tick(4);
    check("count_36", 0, 36, 1'b0);

    // Asynchronous reset between edges.
    #2 reset = 1'b0;
    #1;
    check("async_reset", 0, 0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    tick(1);
    check("first_after_reset", 0, 1, 1'b0);
    tick(1);
    check("count_2", 0, 2, 1'b0);

    bus_main.clockinh = 1'b1;
    tick(2);
    check("inhibit_hold", 0, 2, 1'b0);
    bus_main.clockinh = 1'b0;
    tick(2);
    check("resume_4", 0, 4, 1'b0);

    tick(1019);
    check("all_ones_carry", 0, 1023, 1'b1);
    bus_main.clockinh = 1'b1;
    #1;
    check("inhibit_drops_carry", 0, 1023, 1'b0);
    tick(1);
    check("inhibit_hold_top", 0, 1023, 1'b0);
    bus_main.clockinh = 1'b0;
    #1;
    check("carry_reasserts", 0, 1023, 1'b1);
    tick(1);
    check("wrap_to_zero", 0, 0, 1'b0);

    // Reset during inhibit; clock and inhibit ignored while reset is low.
    tick(5);
    check("count_5", 0, 5, 1'b0);
    bus_main.clockinh = 1'b1;
    #1 reset = 1'b0;
    #1;
    check("reset_in_inhibit", 0, 0, 1'b0);
    tick(2);
    bus_main.clockinh = 1'b0;
    tick(2);
    check("reset_ignores_clock", 0, 0, 1'b0);
    bus_main.clockinh = 1'b1;
    reset = 1'b1;
    tick(1);
    check("post_reset_inhibit", 0, 0, 1'b0);
    bus_main.clockinh = 1'b0;
    tick(1);
    check("post_reset_first", 0, 1, 1'b0);

`ifdef COUNTER_UNIT_LOAD_EN
    bus_main.load      = 1'b1;
    bus_main.loadvalue = 10'd1022;
    bus_main.clockinh  = 1'b1;
    tick(1);
    check("load_over_inhibit", 0, 1022, 1'b0);
    bus_main.load     = 1'b0;
    bus_main.clockinh = 1'b0;
    tick(1);
    check("load_then_1023", 0, 1023, 1'b1);
    tick(1);
    check("load_then_wrap", 0, 0, 1'b0);
    bus_main.load      = 1'b1;
    bus_main.loadvalue = 10'd500;
    reset              = 1'b0;
    tick(1);
    check("reset_over_load", 0, 0, 1'b0);
    reset = 1'b1;
    tick(1);
    check("load_500", 0, 500, 1'b0);
    bus_main.load = 1'b0;
`endif

    // Cascade: main held, low stage enabled for 1024 edges.
    bus_main.clockinh = 1'b1;
    bus_lo.clockinh   = 1'b0;
    tick(1023);
    check("cascade_lo_top", 1, 1023, 1'b1);
    check("cascade_hi_pre", 2, 0, 1'b0);
    tick(1);
    bus_lo.clockinh = 1'b1;
    check("cascade_lo_wrap", 1, 0, 1'b0);
    check("cascade_hi_one", 2, 1, 1'b0);

    #1;
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: pending=%0d, expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/counter_unit.md
COUNTER_UNIT -- requirements
Module: counter_unit

Interface
REQ-001 The block SHALL have one parameter: SIZE, default 8, the base size; counter width W = SIZE+2 (10 bits at default).
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 Port: clock  input  1  rising-edge clock for all state.
REQ-004 Port: reset  input  1  asynchronous active-low reset; 0 clears the counter.
REQ-005 Port: clockinh  input  1  clock inhibit; 1 holds the count.
REQ-006 Port: countoutput  output  W  current count, unsigned binary.
REQ-007 Port: carryout  output  1  terminal-count / cascade carry.

Function
REQ-008 On each rising clock edge with reset=1 and clockinh=0, countoutput SHALL become countoutput+1 modulo 2^W.
REQ-009 On a rising edge with clockinh=1, countoutput SHALL hold its value.
REQ-010 Increment latency SHALL be one clock: the new value is visible after the edge, with no pipeline.
REQ-011 Wrap-around: all-ones (2^W-1) SHALL advance to 0 on the next enabled edge, with no saturation.
REQ-012 carryout SHALL be combinational and equal 1 exactly when countoutput == 2^W-1 and clockinh == 0; otherwise 0.
REQ-013 carryout SHALL drop to 0 when clockinh rises while at all-ones, and reassert when clockinh falls.
REQ-014 Cascading: carryout of one stage driving the inverse of clockinh of the next stage SHALL form a 2W-bit counter.
REQ-015 X/Z on clockinh SHALL be treated as inhibit active (hold); no X SHALL propagate into the count.
REQ-016 countoutput SHALL be driven directly from the count register, so the output is glitch-free.

Reset
REQ-017 reset=0 SHALL immediately, without waiting for a clock, force countoutput=0 and therefore carryout=0.
REQ-018 While reset=0, clock and clockinh SHALL be ignored.
REQ-019 After reset deasserts, the first enabled rising edge SHALL yield countoutput=1.
REQ-020 Reset asserted mid-count or during inhibit SHALL behave identically to REQ-017.

Configuration
REQ-021 The macro COUNTER_UNIT_LOAD_EN SHALL control the parallel-load feature.
REQ-022 With COUNTER_UNIT_LOAD_EN defined, the block SHALL add input ports load (1 bit) and loadvalue (W bits).
REQ-023 With the macro defined, load=1 at a rising edge SHALL set countoutput=loadvalue, taking priority over clockinh.
REQ-024 With the macro defined, reset SHALL still take priority over load.
REQ-025 With the macro undefined, the load and loadvalue ports and the load logic SHALL be absent, and behaviour SHALL be REQ-008..020 only.

Verification
REQ-026 Reset pulse, then 32 enabled edges -> countoutput=32 (0b100000), carryout=0; 4 more edges -> 36.
REQ-027 At count 36, reset=0 asynchronously between edges -> countoutput=0 before the next edge; release, then 2 edges -> 2.
REQ-028 At count 2, clockinh=1 for 2 edges -> count stays 2; clockinh=0, then 2 edges -> 4.
REQ-029 Count to 1023 -> carryout=1; clockinh=1 -> carryout=0 and count holds; clockinh=0, then 1 edge -> countoutput=0, carryout=0.
REQ-030 Two cascaded instances with SIZE=8 -> after 1024 edges, high stage=1 and low stage=0.
REQ-031 With COUNTER_UNIT_LOAD_EN defined: load=1, loadvalue=1022, clockinh=1, then 1 edge -> 1022; load=0, clockinh=0, then 2 edges -> 0 via 1023.
